// File: rtl/mem_if_arbiter.sv
// -----------------------------------------------------------------------------
// mem_if_arbiter
//
// Round-robin arbiter that shares one memory-controller port among
// NUM_CLIENTS requesters. A granted client is wired straight through to the
// controller. For a write, the grant is held until the command is accepted.
// For a read, the grant is held until the read data returns. A watchdog
// releases the port if read data never arrives.
//
// The memory-port bundle is flattened into plain vectors. Client i occupies
// slice [i*W +: W] of each per-client vector.
//
// Ports
//   clk               system clock, rising edge
//   reset             synchronous, active-high reset
//   ctrl_addr_o       address to the memory controller
//   ctrl_data_o       write data to the memory controller
//   ctrl_byte_en_o    byte enables to the memory controller
//   ctrl_rd_o         read strobe to the memory controller
//   ctrl_wr_o         write strobe to the memory controller
//   ctrl_q_i          read data from the memory controller
//   ctrl_available_i  read data valid from the memory controller
//   ctrl_ready_i      controller accepts the presented command
//   cl_addr_i         per-client address
//   cl_data_i         per-client write data
//   cl_byte_en_i      per-client byte enables
//   cl_rd_i           per-client read request
//   cl_wr_i           per-client write request
//   cl_q_o            per-client read data (zero unless owner in WAIT_RD)
//   cl_available_o    per-client read data valid
//   cl_ready_o        per-client command accept
//   grant_valid       a client currently owns the controller
//   grant_idx         index of the owning client
//   timeout_err       one-cycle pulse when the read watchdog fires
// -----------------------------------------------------------------------------
module mem_if_arbiter #(
  parameter int NUM_CLIENTS = 4,
  parameter int RD_TIMEOUT  = 64,
  parameter int ADDR_W      = 16,
  parameter int DATA_W      = 16,
  localparam int BE_W       = DATA_W / 8,
  localparam int IDX_W      = (NUM_CLIENTS > 1) ? $clog2(NUM_CLIENTS) : 1
) (
  input  logic                          clk,
  input  logic                          reset,
  output logic [ADDR_W-1:0]             ctrl_addr_o,
  output logic [DATA_W-1:0]             ctrl_data_o,
  output logic [BE_W-1:0]               ctrl_byte_en_o,
  output logic                          ctrl_rd_o,
  output logic                          ctrl_wr_o,
  input  logic [DATA_W-1:0]             ctrl_q_i,
  input  logic                          ctrl_available_i,
  input  logic                          ctrl_ready_i,
  input  logic [NUM_CLIENTS*ADDR_W-1:0] cl_addr_i,
  input  logic [NUM_CLIENTS*DATA_W-1:0] cl_data_i,
  input  logic [NUM_CLIENTS*BE_W-1:0]   cl_byte_en_i,
  input  logic [NUM_CLIENTS-1:0]        cl_rd_i,
  input  logic [NUM_CLIENTS-1:0]        cl_wr_i,
  output logic [NUM_CLIENTS*DATA_W-1:0] cl_q_o,
  output logic [NUM_CLIENTS-1:0]        cl_available_o,
  output logic [NUM_CLIENTS-1:0]        cl_ready_o,
  output logic                          grant_valid,
  output logic [IDX_W-1:0]              grant_idx,
  output logic                          timeout_err
);

  localparam logic [1:0] ST_IDLE    = 2'd0;
  localparam logic [1:0] ST_GRANT   = 2'd1;
  localparam logic [1:0] ST_WAIT_RD = 2'd2;

  localparam logic [7:0]       WD_LAST  = 8'(RD_TIMEOUT - 1);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_CLIENTS - 1);

  logic [1:0]             state_q, state_d;
  logic                   grant_valid_q, grant_valid_d;
  logic [IDX_W-1:0]       grant_idx_q, grant_idx_d;
  logic [IDX_W-1:0]       rr_ptr_q, rr_ptr_d;
  logic [7:0]             wd_cnt_q, wd_cnt_d;

  logic [NUM_CLIENTS-1:0] req;
  logic [IDX_W-1:0]       cand, pick_idx, next_ptr;
  logic                   pick_found;
  logic                   own_rd, own_wr, own_req, accept, wd_fire;

  assign req     = cl_rd_i | cl_wr_i;
  assign own_rd  = cl_rd_i[grant_idx_q];
  assign own_wr  = cl_wr_i[grant_idx_q];
  assign own_req = own_rd | own_wr;
  assign accept  = (state_q == ST_GRANT) && ctrl_ready_i && own_req;

  // Data arriving on the deadline cycle wins over the watchdog.
  assign wd_fire = (state_q == ST_WAIT_RD) && !ctrl_available_i &&
                   (wd_cnt_q == WD_LAST);

  assign next_ptr = (grant_idx_q == LAST_IDX) ? '0 : grant_idx_q + IDX_W'(1);

  // Round-robin pick: first requester at or above rr_ptr, wrapping.
  // NOTE: every signal written in an always_comb gets a default on entry so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = rr_ptr_q;
    cand       = '0;
    for (int i = 0; i < NUM_CLIENTS; i++) begin
      cand = IDX_W'((int'(rr_ptr_q) + i) % NUM_CLIENTS);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_valid_d = grant_valid_q;
    grant_idx_d   = grant_idx_q;
    rr_ptr_d      = rr_ptr_q;
    wd_cnt_d      = wd_cnt_q;
    case (state_q)
      ST_IDLE: begin
        if (pick_found) begin
          grant_idx_d   = pick_idx;
          grant_valid_d = 1'b1;
          state_d       = ST_GRANT;
        end
      end
      ST_GRANT: begin
        if (accept && own_rd) begin
          state_d  = ST_WAIT_RD;
          wd_cnt_d = '0;
        end else if (accept || !own_req) begin
          // Write accepted or request withdrawn: release and rotate.
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          rr_ptr_d      = next_ptr;
        end
      end
      ST_WAIT_RD: begin
        if (ctrl_available_i || wd_fire) begin
          state_d       = ST_IDLE;
          grant_valid_d = 1'b0;
          rr_ptr_d      = next_ptr;
        end else if (wd_cnt_q != 8'hFF) begin
          wd_cnt_d = wd_cnt_q + 8'd1;
        end
      end
      default: begin
        state_d       = ST_IDLE;
        grant_valid_d = 1'b0;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      grant_valid_q <= 1'b0;
      grant_idx_q   <= '0;
      rr_ptr_q      <= '0;
      wd_cnt_q      <= '0;
    end else begin
      state_q       <= state_d;
      grant_valid_q <= grant_valid_d;
      grant_idx_q   <= grant_idx_d;
      rr_ptr_q      <= rr_ptr_d;
      wd_cnt_q      <= wd_cnt_d;
    end
  end

  // Datapath muxing. Strobes pass only in GRANT, so the controller never
  // sees a second command while a read is outstanding.
  always_comb begin
    ctrl_addr_o    = '0;
    ctrl_data_o    = '0;
    ctrl_byte_en_o = '0;
    ctrl_rd_o      = 1'b0;
    ctrl_wr_o      = 1'b0;
    cl_q_o         = '0;
    cl_available_o = '0;
    cl_ready_o     = '0;
    if (state_q != ST_IDLE) begin
      ctrl_addr_o    = cl_addr_i[grant_idx_q*ADDR_W +: ADDR_W];
      ctrl_data_o    = cl_data_i[grant_idx_q*DATA_W +: DATA_W];
      ctrl_byte_en_o = cl_byte_en_i[grant_idx_q*BE_W +: BE_W];
    end
    if (state_q == ST_GRANT) begin
      ctrl_rd_o               = own_rd;
      ctrl_wr_o               = own_wr;
      cl_ready_o[grant_idx_q] = ctrl_ready_i;
    end
    if (state_q == ST_WAIT_RD) begin
      cl_q_o[grant_idx_q*DATA_W +: DATA_W] = ctrl_q_i;
      cl_available_o[grant_idx_q]          = ctrl_available_i;
    end
  end

  assign grant_valid = grant_valid_q;
  assign grant_idx   = grant_idx_q;
  assign timeout_err = wd_fire;

endmodule

// File: tb/tb_mem_if_arbiter.sv
// -----------------------------------------------------------------------------
// tb_mem_if_arbiter
//
// Directed testbench for mem_if_arbiter (4 clients, RD_TIMEOUT=64).
// Inputs are driven just after the falling edge. Outputs are sampled 1 time
// unit later, which is well away from the rising edge.
// -----------------------------------------------------------------------------
module tb_mem_if_arbiter;

  localparam int NC = 4;
  localparam int AW = 16;
  localparam int DW = 16;
  localparam int BW = DW / 8;

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic [AW-1:0]     ctrl_addr;
  logic [DW-1:0]     ctrl_data;
  logic [BW-1:0]     ctrl_byte_en;
  logic              ctrl_rd, ctrl_wr;
  logic [DW-1:0]     ctrl_q;
  logic              ctrl_available, ctrl_ready;
  logic [NC*AW-1:0]  cl_addr;
  logic [NC*DW-1:0]  cl_data;
  logic [NC*BW-1:0]  cl_be;
  logic [NC-1:0]     cl_rd, cl_wr;
  logic [NC*DW-1:0]  cl_q;
  logic [NC-1:0]     cl_available, cl_ready;
  logic              grant_valid;
  logic [1:0]        grant_idx;
  logic              timeout_err;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  mem_if_arbiter #(
    .NUM_CLIENTS(NC), .RD_TIMEOUT(64), .ADDR_W(AW), .DATA_W(DW)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .ctrl_addr_o      (ctrl_addr),
    .ctrl_data_o      (ctrl_data),
    .ctrl_byte_en_o   (ctrl_byte_en),
    .ctrl_rd_o        (ctrl_rd),
    .ctrl_wr_o        (ctrl_wr),
    .ctrl_q_i         (ctrl_q),
    .ctrl_available_i (ctrl_available),
    .ctrl_ready_i     (ctrl_ready),
    .cl_addr_i        (cl_addr),
    .cl_data_i        (cl_data),
    .cl_byte_en_i     (cl_be),
    .cl_rd_i          (cl_rd),
    .cl_wr_i          (cl_wr),
    .cl_q_o           (cl_q),
    .cl_available_o   (cl_available),
    .cl_ready_o       (cl_ready),
    .grant_valid      (grant_valid),
    .grant_idx        (grant_idx),
    .timeout_err      (timeout_err)
  );

  task automatic clear_inputs();
    cl_rd = '0; cl_wr = '0; cl_addr = '0; cl_data = '0; cl_be = '0;
    ctrl_ready = 1'b0; ctrl_available = 1'b0; ctrl_q = '0;
  endtask

  task automatic client_cmd(input int c, input logic rd, input logic wr,
                            input logic [AW-1:0] addr, input logic [DW-1:0] data);
    cl_rd[c +: 1]        = rd;
    cl_wr[c +: 1]        = wr;
    cl_addr[c*AW +: AW]  = addr;
    cl_data[c*DW +: DW]  = data;
    cl_be[c*BW +: BW]    = '1;
  endtask

  // ---------------------------------------------------------------------------
  task automatic test_reset();
    clear_inputs();
    reset = 1'b1;
    cl_wr[1] = 1'b1;           // a request during reset must not be granted
    repeat (2) @(negedge clk);
    #1;
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL reset_grant_valid: got %0b expected 0", grant_valid); end
    checks++; if (grant_idx !== 2'd0) begin failures++; $display("FAIL reset_grant_idx: got %0d expected 0", grant_idx); end
    checks++; if ({ctrl_rd, ctrl_wr} !== 2'b00) begin failures++; $display("FAIL reset_ctrl_strobes: got %b expected 00", {ctrl_rd, ctrl_wr}); end
    checks++; if ({cl_ready, cl_available} !== '0 || cl_q !== '0) begin failures++; $display("FAIL reset_client_outs: ready=%b avail=%b q=%h expected all zero", cl_ready, cl_available, cl_q); end
    checks++; if (timeout_err !== 1'b0) begin failures++; $display("FAIL reset_timeout_err: got %0b expected 0", timeout_err); end
    @(negedge clk);
    reset = 1'b0;
    clear_inputs();
  endtask

  // All four clients request writes continuously: grants 0,1,2,3,0 on
  // alternating cycles, each with exactly one controller write.
  task automatic test_rotation();
    int order [5];
    int wr_count;
    order = '{0, 1, 2, 3, 0};
    wr_count = 0;
    @(negedge clk);
    for (int c = 0; c < NC; c++) client_cmd(c, 1'b0, 1'b1, 16'(4096 + c), 16'(8192 + c));
    ctrl_ready = 1'b1;
    for (int j = 0; j < 10; j++) begin
      if (j != 0) @(negedge clk);
      #1;
      if (ctrl_wr === 1'b1) wr_count++;
      if (j % 2 == 1) begin
        checks++; if (grant_valid !== 1'b1 || grant_idx !== 2'(order[j/2])) begin failures++; $display("FAIL rotation_grant[%0d]: got valid=%0b idx=%0d expected valid=1 idx=%0d", j, grant_valid, grant_idx, order[j/2]); end
        checks++; if (ctrl_wr !== 1'b1 || ctrl_addr !== 16'(4096 + order[j/2])) begin failures++; $display("FAIL rotation_ctrl[%0d]: got wr=%0b addr=%h expected wr=1 addr=%h", j, ctrl_wr, ctrl_addr, 16'(4096 + order[j/2])); end
      end else begin
        checks++; if (grant_valid !== 1'b0 || ctrl_wr !== 1'b0) begin failures++; $display("FAIL rotation_idle[%0d]: got valid=%0b wr=%0b expected 0 0", j, grant_valid, ctrl_wr); end
      end
    end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (wr_count !== 5) begin failures++; $display("FAIL rotation_wr_count: got %0d expected 5", wr_count); end
  endtask

  // Client 1 granted with ready=0, drops rd in the grant cycle. rr_ptr -> 2,
  // checked by racing clients 1 and 2 afterwards (rr_ptr=2 picks 2).
  task automatic test_withdrawal();
    @(negedge clk);
    client_cmd(1, 1'b1, 1'b0, 16'h0ABC, 16'h0);
    #1;
    checks++; if (grant_valid !== 1'b0 || ctrl_rd !== 1'b0) begin failures++; $display("FAIL wd_req_cycle: got valid=%0b rd=%0b expected 0 0", grant_valid, ctrl_rd); end
    @(negedge clk);
    cl_rd[1] = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b1 || grant_idx !== 2'd1) begin failures++; $display("FAIL wd_grant: got valid=%0b idx=%0d expected 1 1", grant_valid, grant_idx); end
    checks++; if (ctrl_rd !== 1'b0 || cl_ready !== 4'b0000) begin failures++; $display("FAIL wd_no_rd: got rd=%0b ready=%b expected 0 0000", ctrl_rd, cl_ready); end
    @(negedge clk);
    #1;
    checks++; if (grant_valid !== 1'b0 || ctrl_rd !== 1'b0) begin failures++; $display("FAIL wd_release: got valid=%0b rd=%0b expected 0 0", grant_valid, ctrl_rd); end
    @(negedge clk);
    client_cmd(1, 1'b0, 1'b1, 16'h0111, 16'h0);
    client_cmd(2, 1'b0, 1'b1, 16'h0222, 16'h0);
    ctrl_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (grant_idx !== 2'd2 || ctrl_addr !== 16'h0222) begin failures++; $display("FAIL wd_rr_ptr: got idx=%0d addr=%h expected 2 0222", grant_idx, ctrl_addr); end
    @(negedge clk);
    clear_inputs();
  endtask

  // Single write from client 2; afterwards rr_ptr=3 (clients 2 and 3 race -> 3).
  task automatic test_single_write();
    @(negedge clk);
    client_cmd(2, 1'b0, 1'b1, 16'h1234, 16'h55AA);
    ctrl_ready = 1'b1;
    #1;
    checks++; if (ctrl_wr !== 1'b0 || grant_valid !== 1'b0) begin failures++; $display("FAIL sw_req_cycle: got wr=%0b valid=%0b expected 0 0", ctrl_wr, grant_valid); end
    @(negedge clk);
    #1;
    checks++; if (grant_valid !== 1'b1 || grant_idx !== 2'd2) begin failures++; $display("FAIL sw_grant: got valid=%0b idx=%0d expected 1 2", grant_valid, grant_idx); end
    checks++; if (ctrl_wr !== 1'b1 || ctrl_rd !== 1'b0 || ctrl_addr !== 16'h1234 || ctrl_data !== 16'h55AA || ctrl_byte_en !== 2'b11) begin failures++; $display("FAIL sw_ctrl: got wr=%0b rd=%0b addr=%h data=%h be=%b expected 1 0 1234 55aa 11", ctrl_wr, ctrl_rd, ctrl_addr, ctrl_data, ctrl_byte_en); end
    checks++; if (cl_ready !== 4'b0100) begin failures++; $display("FAIL sw_ready: got %b expected 0100", cl_ready); end
    @(negedge clk);
    cl_wr[2] = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b0 || ctrl_wr !== 1'b0 || ctrl_addr !== 16'h0) begin failures++; $display("FAIL sw_release: got valid=%0b wr=%0b addr=%h expected 0 0 0000", grant_valid, ctrl_wr, ctrl_addr); end
    @(negedge clk);
    client_cmd(2, 1'b0, 1'b1, 16'h0202, 16'h0);
    client_cmd(3, 1'b0, 1'b1, 16'h0303, 16'h0);
    @(negedge clk);
    #1;
    checks++; if (grant_idx !== 2'd3 || ctrl_addr !== 16'h0303) begin failures++; $display("FAIL sw_rr_ptr: got idx=%0d addr=%h expected 3 0303", grant_idx, ctrl_addr); end
    @(negedge clk);
    clear_inputs();
  endtask

  // Single read from client 0; data returns three cycles after accept.
  task automatic test_single_read();
    @(negedge clk);
    client_cmd(0, 1'b1, 1'b0, 16'h0040, 16'h0);
    ctrl_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (grant_idx !== 2'd0 || ctrl_rd !== 1'b1 || cl_ready !== 4'b0001) begin failures++; $display("FAIL sr_accept: got idx=%0d rd=%0b ready=%b expected 0 1 0001", grant_idx, ctrl_rd, cl_ready); end
    @(negedge clk);
    cl_rd[0] = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b1 || ctrl_rd !== 1'b0 || cl_ready !== 4'b0000 || ctrl_addr !== 16'h0040) begin failures++; $display("FAIL sr_wait: got valid=%0b rd=%0b ready=%b addr=%h expected 1 0 0000 0040", grant_valid, ctrl_rd, cl_ready, ctrl_addr); end
    @(negedge clk);
    @(negedge clk);
    ctrl_available = 1'b1;
    ctrl_q = 16'hBEEF;
    #1;
    checks++; if (cl_q[15:0] !== 16'hBEEF || cl_available !== 4'b0001) begin failures++; $display("FAIL sr_data: got q0=%h avail=%b expected beef 0001", cl_q[15:0], cl_available); end
    checks++; if (cl_q[63:16] !== 48'h0 || timeout_err !== 1'b0) begin failures++; $display("FAIL sr_others: got q[63:16]=%h terr=%0b expected 0 0", cl_q[63:16], timeout_err); end
    @(negedge clk);
    ctrl_available = 1'b0;
    ctrl_q = '0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL sr_release: got valid=%0b expected 0", grant_valid); end
  endtask

  // Read from client 1 with no data: timeout_err pulses 64 cycles after
  // accept, late data is dropped, next grant goes to client 2.
  task automatic test_timeout();
    @(negedge clk);
    client_cmd(1, 1'b1, 1'b0, 16'h0077, 16'h0);
    ctrl_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (grant_idx !== 2'd1 || ctrl_rd !== 1'b1) begin failures++; $display("FAIL to_accept: got idx=%0d rd=%0b expected 1 1", grant_idx, ctrl_rd); end
    for (int k = 1; k <= 65; k++) begin
      @(negedge clk);
      if (k == 1) cl_rd[1] = 1'b0;
      if (k == 65) begin ctrl_available = 1'b1; ctrl_q = 16'hBEEF; end
      #1;
      checks++; if (timeout_err !== (k == 64)) begin failures++; $display("FAIL to_pulse[%0d]: got %0b expected %0b", k, timeout_err, (k == 64)); end
      if (k == 64) begin
        checks++; if (grant_valid !== 1'b1) begin failures++; $display("FAIL to_hold: got valid=%0b expected 1", grant_valid); end
      end
      if (k == 65) begin
        checks++; if (grant_valid !== 1'b0 || cl_available !== 4'b0000 || cl_q !== '0) begin failures++; $display("FAIL to_late_data: got valid=%0b avail=%b q=%h expected 0 0000 0", grant_valid, cl_available, cl_q); end
      end
    end
    @(negedge clk);
    clear_inputs();
    client_cmd(1, 1'b0, 1'b1, 16'h0111, 16'h0);
    client_cmd(2, 1'b0, 1'b1, 16'h0222, 16'h0);
    ctrl_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (grant_idx !== 2'd2) begin failures++; $display("FAIL to_next_grant: got idx=%0d expected 2", grant_idx); end
    @(negedge clk);
    clear_inputs();
  endtask

  // Data on the very cycle the watchdog would fire: delivery wins.
  task automatic test_avail_at_deadline();
    @(negedge clk);
    client_cmd(3, 1'b1, 1'b0, 16'h0033, 16'h0);
    ctrl_ready = 1'b1;
    @(negedge clk);
    #1;
    checks++; if (grant_idx !== 2'd3 || ctrl_rd !== 1'b1) begin failures++; $display("FAIL dl_accept: got idx=%0d rd=%0b expected 3 1", grant_idx, ctrl_rd); end
    for (int k = 1; k <= 64; k++) begin
      @(negedge clk);
      if (k == 1) cl_rd[3] = 1'b0;
      if (k == 64) begin ctrl_available = 1'b1; ctrl_q = 16'hCAFE; end
      #1;
    end
    checks++; if (timeout_err !== 1'b0 || cl_available !== 4'b1000 || cl_q[63:48] !== 16'hCAFE) begin failures++; $display("FAIL dl_data_wins: got terr=%0b avail=%b q3=%h expected 0 1000 cafe", timeout_err, cl_available, cl_q[63:48]); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (grant_valid !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL dl_release: got valid=%0b terr=%0b expected 0 0", grant_valid, timeout_err); end
  endtask

  // Reset taken mid-read; data arriving two cycles later is ignored.
  task automatic test_reset_wait_rd();
    @(negedge clk);
    client_cmd(0, 1'b1, 1'b0, 16'h0050, 16'h0);
    ctrl_ready = 1'b1;
    @(negedge clk);
    @(negedge clk);
    cl_rd[0] = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b1 || grant_idx !== 2'd0) begin failures++; $display("FAIL rw_in_wait: got valid=%0b idx=%0d expected 1 0", grant_valid, grant_idx); end
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1;
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL rw_after_reset: got valid=%0b expected 0", grant_valid); end
    @(negedge clk);
    ctrl_available = 1'b1;
    ctrl_q = 16'hBEEF;
    #1;
    checks++; if (cl_available !== 4'b0000 || cl_q !== '0 || grant_valid !== 1'b0 || timeout_err !== 1'b0) begin failures++; $display("FAIL rw_data_ignored: got avail=%b q=%h valid=%0b terr=%0b expected 0000 0 0 0", cl_available, cl_q, grant_valid, timeout_err); end
    @(negedge clk);
    clear_inputs();
    #1;
    checks++; if (grant_valid !== 1'b0) begin failures++; $display("FAIL rw_stays_idle: got valid=%0b expected 0", grant_valid); end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_rotation();
    test_withdrawal();
    test_single_write();
    test_single_read();
    test_timeout();
    test_avail_at_deadline();
    test_reset_wait_rd();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation did not complete within 100000 time units");
    $fatal(1, "global timeout");
  end

endmodule
